// File: rtl/gpg_spi_pkg.sv
// rtl/gpg_spi_pkg.sv - shared states, opcodes and helpers for the GoPiGo3 SPI command sequencer
package gpg_spi_pkg;

    typedef enum logic [2:0] {
        STARTUP   = 3'd0,
        IDLE      = 3'd1,
        SS_SETUP  = 3'd2,
        ISSUE     = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_DONE = 3'd5,
        SS_HOLD   = 3'd6
    } state_t;

    localparam logic [7:0] OP_SET_LED       = 8'h06;
    localparam logic [7:0] OP_SET_MOTOR_DPS = 8'h0E;

    localparam logic [7:0] PORT_LEFT  = 8'h01;
    localparam logic [7:0] PORT_RIGHT = 8'h02;
    localparam logic [7:0] PORT_BOTH  = 8'h03;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpg_spi_clkdiv.sv
// rtl/gpg_spi_clkdiv.sv - ena_2clk strobe generator, one pulse per CLK_DIV cycles, re-phased by i_clr
module gpg_spi_clkdiv
    import gpg_spi_pkg::*;
#(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_ena
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] r_cnt;

    // Free-running divider; a byte start restarts the phase so every byte sees the same timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == W'(CLK_DIV - 1))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ena = (r_cnt == W'(CLK_DIV - 1));

endmodule

// File: rtl/gpg_spi_cmd_seq.sv
// rtl/gpg_spi_cmd_seq.sv - GoPiGo3 SPI command sequencer; GPG_RSP_CAPTURE_EN adds pad-byte response capture
module gpg_spi_cmd_seq
    import gpg_spi_pkg::*;
#(
    parameter int         CLK_DIV      = 12,
    parameter int         STARTUP_CYC  = 500,
    parameter int         SS_SETUP_CYC = 64,
    parameter int         SS_HOLD_CYC  = 16,
    parameter int         MAX_PAYLOAD  = 4,
    parameter int         PAD_BYTES    = 2,
    parameter logic [7:0] GPG_ADDR     = 8'h08,
    parameter int         TMO_CYC      = 4096
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [7:0]                       cmd_op,
    input  logic [$clog2(MAX_PAYLOAD+1)-1:0] cmd_len,
    input  logic [8*MAX_PAYLOAD-1:0]         cmd_payload,
    input  logic                             busy_spi,
    input  logic [7:0]                       rx_spi,
    output logic                             start,
    output logic [7:0]                       data_spi,
    output logic                             ena_2clk,
    output logic                             SSBar,
    output logic                             done,
    output logic                             err_tmo
`ifdef GPG_RSP_CAPTURE_EN
    ,
    output logic [8*PAD_BYTES-1:0]           rsp_data,
    output logic                             rsp_valid
`endif
);

    localparam int LEN_W     = $clog2(MAX_PAYLOAD + 1);
    localparam int TOTAL_MAX = 2 + MAX_PAYLOAD + PAD_BYTES;
    localparam int IDX_W     = $clog2(TOTAL_MAX + 1);
    localparam int CNT_MAX   = max_of(STARTUP_CYC, max_of(SS_SETUP_CYC, SS_HOLD_CYC));
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TMO_W     = $clog2(TMO_CYC + 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [TMO_W-1:0]         r_tmo;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_total;
    logic [7:0]               r_op;
    logic [LEN_W-1:0]         r_len;
    logic [8*MAX_PAYLOAD-1:0] r_payload;
    logic                     r_busy_rg;
    logic                     r_done;
    logic                     r_err;

    logic                     w_ena;
    logic                     w_start;
    logic                     w_ready;
    logic                     w_ssbar;
    logic                     w_accept;
    logic                     w_adv;
    logic                     w_done_nxt;
    logic                     w_err_nxt;
    logic                     w_cnt_last;
    logic                     w_tmo_hit;
    logic [LEN_W-1:0]         w_len_clamped;
    logic [7:0]               w_byte;

    gpg_spi_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start),
        .o_ena (w_ena)
    );

    assign w_len_clamped = (cmd_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : cmd_len;
    assign w_tmo_hit     = (r_tmo == TMO_W'(TMO_CYC - 1));

    // Terminal count of the shared delay counter for whichever timed state is active.
    always_comb begin
        w_cnt_last = 1'b0;
        case (r_state)
            STARTUP:  w_cnt_last = (r_cnt == CNT_W'(STARTUP_CYC - 1));
            SS_SETUP: w_cnt_last = (r_cnt == CNT_W'(SS_SETUP_CYC - 1));
            SS_HOLD:  w_cnt_last = (r_cnt == CNT_W'(SS_HOLD_CYC - 1));
            default:  w_cnt_last = 1'b0;
        endcase
    end

    // Frame byte selection: address, opcode, payload MSB byte first, then zero padding.
    always_comb begin
        w_byte = 8'h00;
        if (r_idx == '0) begin
            w_byte = GPG_ADDR;
        end else if (r_idx == IDX_W'(1)) begin
            w_byte = r_op;
        end else begin
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                if ((r_idx == IDX_W'(k + 2)) && (LEN_W'(k) < r_len)) begin
                    w_byte = r_payload[8*(MAX_PAYLOAD-1-k) +: 8];
                end
            end
        end
    end

    // Next-state and per-state strobes of the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ready     = 1'b0;
        w_ssbar     = 1'b1;
        w_accept    = 1'b0;
        w_adv       = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            STARTUP: begin
                if (w_cnt_last) w_state_nxt = IDLE;
            end
            IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SS_SETUP;
                end
            end
            SS_SETUP: begin
                w_ssbar = 1'b0;
                if (w_cnt_last) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_ssbar = 1'b0;
                if (!r_busy_rg) begin
                    w_start     = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                w_ssbar = 1'b0;
                if (r_busy_rg) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                w_ssbar = 1'b0;
                if (!r_busy_rg) begin
                    w_adv       = 1'b1;
                    w_state_nxt = ((r_idx + IDX_W'(1)) == r_total) ? SS_HOLD : ISSUE;
                end else if (w_tmo_hit) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            SS_HOLD: begin
                w_ssbar = 1'b0;
                if (w_cnt_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = STARTUP;
        endcase
    end

    // State register; reset always restarts the power-up delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= STARTUP;
        else        r_state <= w_state_nxt;
    end

    // Delay counter for STARTUP / SS_SETUP / SS_HOLD, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == STARTUP) || (r_state == SS_SETUP) || (r_state == SS_HOLD)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Watchdog on the SPI master handshake, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo <= '0;
        end else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    // Command latch and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_len     <= '0;
            r_payload <= '0;
            r_total   <= '0;
            r_idx     <= '0;
        end else if (w_accept) begin
            r_op      <= cmd_op;
            r_len     <= w_len_clamped;
            r_payload <= cmd_payload;
            r_total   <= IDX_W'(2) + IDX_W'(w_len_clamped) + IDX_W'(PAD_BYTES);
            r_idx     <= '0;
        end else if (w_adv) begin
            r_idx     <= r_idx + 1'b1;
        end
    end

    // Busy as seen at ena_2clk granularity: rises at once, falls only on an enable strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_busy_rg <= 1'b1;
        else if (busy_spi) r_busy_rg <= 1'b1;
        else if (w_ena)    r_busy_rg <= 1'b0;
    end

    // Completion pulses land in the first IDLE cycle, when SSBar is already high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign cmd_ready = w_ready;
    assign start     = w_start;
    assign SSBar     = w_ssbar;
    assign ena_2clk  = w_ena;
    assign done      = r_done;
    assign err_tmo   = r_err;
    assign data_spi  = ((r_state == ISSUE) || (r_state == WAIT_BUSY) || (r_state == WAIT_DONE))
                       ? w_byte : 8'h00;

`ifdef GPG_RSP_CAPTURE_EN
    localparam int RSP_W = 8 * PAD_BYTES;

    logic [RSP_W-1:0] r_rsp;
    logic             r_rsp_valid;
    logic             w_pad_fall;

    assign w_pad_fall = (r_state == WAIT_DONE) && !r_busy_rg
                        && (r_idx >= (IDX_W'(2) + IDX_W'(r_len)));

    // Shift in slave response bytes; the first pad byte ends up in the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_pad_fall) r_rsp <= (r_rsp << 8) | RSP_W'(rx_spi);
            r_rsp_valid <= w_done_nxt;
        end
    end

    assign rsp_data  = r_rsp;
    assign rsp_valid = r_rsp_valid;
`else
    logic [7:0] w_unused_rx;
    assign w_unused_rx = rx_spi;
`endif

endmodule

// File: tb/tb_gpg_spi_cmd_seq.sv
// tb/tb_gpg_spi_cmd_seq.sv - self-checking bench for gpg_spi_cmd_seq with behavioural SPI master
module tb_gpg_spi_cmd_seq;
    import gpg_spi_pkg::*;

    localparam int CLK_DIV      = 12;
    localparam int STARTUP_CYC  = 500;
    localparam int SS_SETUP_CYC = 64;
    localparam int SS_HOLD_CYC  = 16;
    localparam int MAX_PAYLOAD  = 4;
    localparam int PAD_BYTES    = 2;
    localparam int TMO_CYC      = 4096;
    localparam int LEN_W        = $clog2(MAX_PAYLOAD + 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [7:0]               cmd_op = 8'h00;
    logic [LEN_W-1:0]         cmd_len = '0;
    logic [8*MAX_PAYLOAD-1:0] cmd_payload = '0;
    logic                     busy_spi = 1'b0;
    logic [7:0]               rx_spi = 8'h00;
    logic                     start;
    logic [7:0]               data_spi;
    logic                     ena_2clk;
    logic                     SSBar;
    logic                     done;
    logic                     err_tmo;
`ifdef GPG_RSP_CAPTURE_EN
    logic [8*PAD_BYTES-1:0]   rsp_data;
    logic                     rsp_valid;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];

    int m_st = 0;
    int m_cnt = 0;
    int m_byte = 0;
    bit slave_dead = 1'b0;
    int pad_first = 0;

    gpg_spi_cmd_seq #(
        .CLK_DIV      (CLK_DIV),
        .STARTUP_CYC  (STARTUP_CYC),
        .SS_SETUP_CYC (SS_SETUP_CYC),
        .SS_HOLD_CYC  (SS_HOLD_CYC),
        .MAX_PAYLOAD  (MAX_PAYLOAD),
        .PAD_BYTES    (PAD_BYTES),
        .GPG_ADDR     (8'h08),
        .TMO_CYC      (TMO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .busy_spi    (busy_spi),
        .rx_spi      (rx_spi),
        .start       (start),
        .data_spi    (data_spi),
        .ena_2clk    (ena_2clk),
        .SSBar       (SSBar),
        .done        (done),
        .err_tmo     (err_tmo)
`ifdef GPG_RSP_CAPTURE_EN
        ,
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural SPI master: busy rises 2 ena_2clk pulses after start and lasts 16 pulses.
    always @(negedge clk) begin
        if (!rst_n || SSBar) begin
            m_st     = 0;
            m_cnt    = 0;
            m_byte   = 0;
            busy_spi = 1'b0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_st  = 1;
                    m_cnt = 0;
                end
                1: if (ena_2clk && !slave_dead) begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        busy_spi = 1'b1;
                        m_st     = 2;
                        m_cnt    = 0;
                    end
                end
                default: if (ena_2clk) begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        busy_spi = 1'b0;
                        rx_spi   = (m_byte == pad_first) ? 8'hA5 :
                                   (m_byte == pad_first + 1) ? 8'h5A : 8'h3C;
                        m_byte++;
                        m_st     = 0;
                    end
                end
            endcase
        end
    end

    task automatic test_reset();
        int n;
        int st;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (SSBar !== 1'b1)     $display("FAIL reset_ssbar: got %b want 1", SSBar);     else n_pass++;
        n_checks++; if (start !== 1'b0)     $display("FAIL reset_start: got %b want 0", start);     else n_pass++;
        n_checks++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done);       else n_pass++;
        n_checks++; if (err_tmo !== 1'b0)   $display("FAIL reset_err: got %b want 0", err_tmo);     else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else n_pass++;
        n_checks++; if (ena_2clk !== 1'b0)  $display("FAIL reset_ena: got %b want 0", ena_2clk);    else n_pass++;
        n_checks++; if (data_spi !== 8'h00) $display("FAIL reset_data: got %h want 00", data_spi);  else n_pass++;
        rst_n       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = OP_SET_MOTOR_DPS;
        cmd_len     = LEN_W'(1);
        cmd_payload = 32'h55000000;
        n  = -1;
        st = 0;
        for (int i = 1; i <= STARTUP_CYC + 100; i++) begin
            @(negedge clk);
            if (start) st++;
            if (i == STARTUP_CYC - 50) cmd_valid = 1'b0;
            if (cmd_ready) begin
                n = i;
                break;
            end
        end
        cmd_valid = 1'b0;
        n_checks++; if (n != STARTUP_CYC) $display("FAIL startup_ready_delay: got %0d want %0d", n, STARTUP_CYC); else n_pass++;
        n_checks++; if (st != 0) $display("FAIL startup_no_start: got %0d starts want 0", st); else n_pass++;
    endtask

    task automatic run_frame(input string name, input logic [7:0] op, input int len,
                             input logic [8*MAX_PAYLOAD-1:0] pl);
        int eff;
        int n_exp;
        int sscnt;
        int nst;
        int ndone;
        int nerr;
        int done_at;
        bit first;
        logic [7:0] b;
        eff = (len > MAX_PAYLOAD) ? MAX_PAYLOAD : len;
        exp_q.delete();
        exp_q.push_back(8'h08);
        exp_q.push_back(op);
        for (int k = 0; k < eff; k++) exp_q.push_back(pl[8*(MAX_PAYLOAD-1-k) +: 8]);
        for (int k = 0; k < PAD_BYTES; k++) exp_q.push_back(8'h00);
        n_exp     = exp_q.size();
        pad_first = 2 + eff;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_len     = LEN_W'(len);
        cmd_payload = pl;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (SSBar !== 1'b0) $display("FAIL %s ssbar_after_accept: got %b want 0", name, SSBar); else n_pass++;
        sscnt   = 1;
        nst     = 0;
        ndone   = 0;
        nerr    = 0;
        done_at = -1;
        first   = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (start) begin
                if (first) begin
                    n_checks++; if (sscnt != SS_SETUP_CYC) $display("FAIL %s ss_setup: got %0d want %0d", name, sscnt, SS_SETUP_CYC); else n_pass++;
                    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL %s ready_busy: got %b want 0", name, cmd_ready); else n_pass++;
                    first = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s extra_byte: got %h want none", name, data_spi);
                end else begin
                    b = exp_q.pop_front();
                    n_checks++; if (data_spi !== b) $display("FAIL %s byte%0d: got %h want %h", name, nst, data_spi, b); else n_pass++;
                end
                nst++;
            end else if (first) begin
                sscnt++;
            end
            if (err_tmo) nerr++;
`ifdef GPG_RSP_CAPTURE_EN
            if (rsp_valid || done) begin
                n_checks++; if (rsp_valid !== done) $display("FAIL %s rsp_valid_with_done: got %b want %b", name, rsp_valid, done); else n_pass++;
            end
`endif
            if (done) begin
                ndone++;
                n_checks++; if (SSBar !== 1'b1) $display("FAIL %s ssbar_at_done: got %b want 1", name, SSBar); else n_pass++;
`ifdef GPG_RSP_CAPTURE_EN
                n_checks++; if (rsp_data !== 16'hA55A) $display("FAIL %s rsp_data: got %h want a55a", name, rsp_data); else n_pass++;
`endif
                if (done_at < 0) done_at = i;
            end
            if (done_at >= 0 && i >= done_at + 30) break;
        end
        n_checks++; if (nst != n_exp) $display("FAIL %s start_count: got %0d want %0d", name, nst, n_exp); else n_pass++;
        n_checks++; if (ndone != 1) $display("FAIL %s done_count: got %0d want 1", name, ndone); else n_pass++;
        n_checks++; if (nerr != 0) $display("FAIL %s err_count: got %0d want 0", name, nerr); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL %s ready_after: got %b want 1", name, cmd_ready); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_motor_dps();
        run_frame("motor_dps", OP_SET_MOTOR_DPS, 3, {8'h03, 8'h03, 8'hE8, 8'h00});
    endtask

    task automatic test_len_bounds();
        run_frame("len0_led", OP_SET_LED, 0, 32'hDEADBEEF);
        run_frame("len7_clamp", OP_SET_MOTOR_DPS, 7, 32'h11223344);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", OP_SET_LED, 2, {PORT_BOTH, 8'h7F, 8'h00, 8'h00});
        run_frame("b2b_b", OP_SET_MOTOR_DPS, 4, $urandom());
    endtask

    task automatic test_timeout();
        int k;
        int nd;
        bit got;
        slave_dead = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = OP_SET_MOTOR_DPS;
        cmd_len     = LEN_W'(1);
        cmd_payload = 32'h01000000;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++; if (!got) $display("FAIL tmo_first_start: got none want start"); else n_pass++;
        k  = -1;
        nd = 0;
        for (int i = 1; i <= TMO_CYC + 50; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (err_tmo) begin
                k = i;
                n_checks++; if (SSBar !== 1'b1) $display("FAIL tmo_ssbar: got %b want 1", SSBar); else n_pass++;
                n_checks++; if (cmd_ready !== 1'b1) $display("FAIL tmo_ready: got %b want 1", cmd_ready); else n_pass++;
`ifdef GPG_RSP_CAPTURE_EN
                n_checks++; if (rsp_valid !== 1'b0) $display("FAIL tmo_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
`endif
                break;
            end
        end
        n_checks++; if (k != TMO_CYC + 1) $display("FAIL tmo_latency: got %0d want %0d", k, TMO_CYC + 1); else n_pass++;
        @(negedge clk);
        if (done) nd++;
        n_checks++; if (err_tmo !== 1'b0) $display("FAIL tmo_pulse_width: got %b want 0", err_tmo); else n_pass++;
        n_checks++; if (nd != 0) $display("FAIL tmo_no_done: got %0d want 0", nd); else n_pass++;
        slave_dead = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int ns;
        int n;
        int st;
        int nlow;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = OP_SET_MOTOR_DPS;
        cmd_len     = LEN_W'(3);
        cmd_payload = 32'hAABBCC00;
        @(negedge clk);
        cmd_valid = 1'b0;
        ns = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (start) begin
                ns++;
                if (ns == 4) break;
            end
        end
        n_checks++; if (ns != 4) $display("FAIL midrst_reach_byte3: got %0d starts want 4", ns); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (SSBar !== 1'b1) $display("FAIL midrst_ssbar: got %b want 1", SSBar); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL midrst_start: got %b want 0", start); else n_pass++;
        n_checks++; if (data_spi !== 8'h00) $display("FAIL midrst_data: got %h want 00", data_spi); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n    = -1;
        st   = 0;
        nlow = 0;
        for (int i = 1; i <= STARTUP_CYC + 100; i++) begin
            @(negedge clk);
            if (start) st++;
            if (!SSBar) nlow++;
            if (cmd_ready) begin
                n = i;
                break;
            end
        end
        n_checks++; if (n != STARTUP_CYC) $display("FAIL midrst_startup_delay: got %0d want %0d", n, STARTUP_CYC); else n_pass++;
        n_checks++; if (st != 0 || nlow != 0) $display("FAIL midrst_quiet: got %0d starts %0d low want 0 0", st, nlow); else n_pass++;
        run_frame("after_reset", OP_SET_LED, 1, 32'h42000000);
    endtask

`ifdef GPG_RSP_CAPTURE_EN
    task automatic test_rsp_capture();
        run_frame("rsp_capture", OP_SET_MOTOR_DPS, 1, 32'h99000000);
        n_checks++; if (rsp_data !== 16'hA55A) $display("FAIL rsp_hold: got %h want a55a", rsp_data); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rsp_valid_idle: got %b want 0", rsp_valid); else n_pass++;
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_motor_dps();
        test_len_bounds();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
`ifdef GPG_RSP_CAPTURE_EN
        test_rsp_capture();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
